// File: rtl/pbit_state_histogram.sv
// rtl/pbit_state_histogram.sv - p-bit state vector sampler and histogram streamer
//
// Purpose: captures the live p-bit state vector with a two-flop input stage.
//   On start it clears one counter per possible state. It then samples every
//   decim+1 cycles for win_len samples and streams the 2^NBITS bin records out
//   in index order.
// Ports:
//   sample_clk, rst_n         clock, asynchronous active-low reset
//   m_in                      live p-bit states (value = bin index)
//   start, abort              run control pulses (abort wins)
//   win_len, decim            window length and decimation, latched on start
//   busy, done, sat_flag      status
//   out_valid/out_ready       record handshake
//   out_idx/out_count/out_last  record payload
module pbit_state_histogram #(
  parameter int NBITS = 5,
  parameter int CNT_W = 24,
  parameter int WIN_W = 24,
  parameter int DEC_W = 8
) (
  input  logic             sample_clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] m_in,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [DEC_W-1:0] decim,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             sat_flag
);

  localparam int NBINS = 1 << NBITS;
  localparam logic [NBITS-1:0] LAST_IDX = {NBITS{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACQ, S_DUMP} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] m_s1_q, m_s1_d, m_s2_q, m_s2_d;
  logic [WIN_W-1:0] win_len_q, win_len_d, smp_cnt_q, smp_cnt_d;
  logic [DEC_W-1:0] decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [NBITS-1:0] clr_idx_q, clr_idx_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [NBITS-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             done_q, done_d, sat_q, sat_d;

  // Bin storage: no reset, CLEAR always runs before any read.
  logic [CNT_W-1:0] bin_q [NBINS];
  logic             bin_we;
  logic [NBITS-1:0] bin_wa;
  logic [CNT_W-1:0] bin_wd;
  logic [CNT_W-1:0] cur_cnt;
  logic [NBITS-1:0] nxt_idx;

  always_comb begin
    state_d     = state_q;
    m_s1_d      = m_in;
    m_s2_d      = m_s1_q;
    win_len_d   = win_len_q;
    decim_d     = decim_q;
    smp_cnt_d   = smp_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    clr_idx_d   = clr_idx_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    bin_we      = 1'b0;
    bin_wa      = m_s2_q;
    bin_wd      = '0;
    cur_cnt     = bin_q[m_s2_q];
    nxt_idx     = out_idx_q + 1'b1;

    if (abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            win_len_d = win_len;
            decim_d   = decim;
            sat_d     = 1'b0;
            clr_idx_d = '0;
            state_d   = S_CLEAR;
          end
        end
        S_CLEAR: begin
          bin_we    = 1'b1;
          bin_wa    = clr_idx_q;
          bin_wd    = '0;
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            dec_cnt_d = '0;
            smp_cnt_d = '0;
            state_d   = S_ACQ;
          end
        end
        S_ACQ: begin
          // The window-complete test runs one cycle after the last increment,
          // so that increment is already in bin_q when bin 0 is read here.
          if (smp_cnt_q == win_len_q) begin
            out_valid_d = 1'b1;
            out_idx_d   = '0;
            out_count_d = bin_q[0];
            out_last_d  = (NBINS == 1);
            state_d     = S_DUMP;
          end else if (dec_cnt_q == decim_q) begin
            // Single-cycle read-modify-write, so back-to-back hits on one bin
            // see each other's result without a bypass path.
            dec_cnt_d = '0;
            smp_cnt_d = smp_cnt_q + 1'b1;
            bin_we    = 1'b1;
            bin_wa    = m_s2_q;
            if (cur_cnt == CNT_MAX) begin
              bin_wd = cur_cnt;
              sat_d  = 1'b1;
            end else begin
              bin_wd = cur_cnt + 1'b1;
            end
          end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
          end
        end
        S_DUMP: begin
          if (out_ready) begin
            if (out_last_q) begin
              done_d      = 1'b1;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              state_d     = S_IDLE;
            end else begin
              out_idx_d   = nxt_idx;
              out_count_d = bin_q[nxt_idx];
              out_last_d  = (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_s1_q      <= '0;
      m_s2_q      <= '0;
      win_len_q   <= '0;
      decim_q     <= '0;
      smp_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      clr_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_s1_q      <= m_s1_d;
      m_s2_q      <= m_s2_d;
      win_len_q   <= win_len_d;
      decim_q     <= decim_d;
      smp_cnt_q   <= smp_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      clr_idx_q   <= clr_idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  always_ff @(posedge sample_clk) begin
    if (bin_we) begin
      bin_q[bin_wa] <= bin_wd;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;

endmodule
